logic_unit_pipe: RTL and testbench

- Parametrised successor to the single-op, zero-latency bitwise units in the arith library.
- Joins three elastic channels: lhs, rhs and a per-token opcode. Computes AND/OR/XOR/XNOR selected by the opcode.
- Result passes through a stallable elastic pipeline of LATENCY register stages, giving full throughput.
- Used where timing closure needs registered logic ops, or where one op-typed unit is shared across operations.

---
 rtl/logic_unit_pipe_pkg.sv | 13 +
 rtl/elastic_reg_stage.sv | 45 ++++
 rtl/join_type.sv | 27 ++
 rtl/logic_unit_pipe.sv | 94 +++++++++
 tb/tb_logic_unit_pipe.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pipe_pkg.sv
// Opcode encoding shared by the logic unit and the blocks that drive it.
package logic_unit_pipe_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } op_e;

endpackage

// File: rtl/elastic_reg_stage.sv
// One valid/ready/data register slice: loads whenever it is empty or its
// downstream is taking the current token, otherwise holds.
module elastic_reg_stage #(
    parameter int unsigned DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DATA_TYPE-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    logic                 valid_q, valid_d;
    logic [DATA_TYPE-1:0] data_q,  data_d;

    assign ready_o = ~valid_q | ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
    end

    // NOTE: state uses non-blocking assignments so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            // NOTE: the data register is reset as well so result reads 0 after reset, not stale data.
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/join_type.sv
// N-way elastic join: the output is valid only when every input is valid, and
// each input is told ready only when all of its siblings are valid.
module join_type #(
    parameter int unsigned SIZE = 3
) (
    input  logic [SIZE-1:0] ins_valid_i,
    input  logic            outs_ready_i,
    output logic [SIZE-1:0] ins_ready_o,
    output logic            outs_valid_o
);

    assign outs_valid_o = &ins_valid_i;

    for (genvar i = 0; i < SIZE; i++) begin : g_ready
        logic [SIZE-1:0] others;

        // NOTE: every bit of others gets a default before the override, so no latch is inferred.
        always_comb begin
            others    = ins_valid_i;
            others[i] = 1'b1;
        end

        // Own valid is masked out, so there is no valid-to-own-ready path.
        assign ins_ready_o[i] = outs_ready_i & (&others);
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Elastic AND/OR/XOR/XNOR unit: joins lhs, rhs and op channels, then carries the
// result through LATENCY stallable register stages (0 = combinational).
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int unsigned DATA_TYPE = 32,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] lhs,
    input  logic                 lhs_valid,
    output logic                 lhs_ready,
    input  logic [DATA_TYPE-1:0] rhs,
    input  logic                 rhs_valid,
    output logic                 rhs_ready,
    input  logic [OP_W-1:0]      op,
    input  logic                 op_valid,
    output logic                 op_ready,
    output logic [DATA_TYPE-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ready
);

    logic                 in_valid;
    logic                 s0_ready;
    logic [2:0]           join_ready;
    logic [DATA_TYPE-1:0] op_data;

    join_type #(
        .SIZE (3)
    ) u_join (
        .ins_valid_i  ({op_valid, rhs_valid, lhs_valid}),
        .outs_ready_i (s0_ready),
        .ins_ready_o  (join_ready),
        .outs_valid_o (in_valid)
    );

    assign lhs_ready = join_ready[0];
    assign rhs_ready = join_ready[1];
    assign op_ready  = join_ready[2];

    always_comb begin
        op_data = '0;
        case (op_e'(op))
            OP_AND:  op_data = lhs & rhs;
            OP_OR:   op_data = lhs | rhs;
            OP_XOR:  op_data = lhs ^ rhs;
            OP_XNOR: op_data = ~(lhs ^ rhs);
        endcase
    end

    if (LATENCY == 0) begin : g_comb
        assign result       = op_data;
        assign result_valid = in_valid;
        assign s0_ready     = result_ready;
    end else begin : g_pipe
        logic [LATENCY:0]                pipe_valid;
        logic [LATENCY:0][DATA_TYPE-1:0] pipe_data;

        assign pipe_valid[0] = in_valid;
        assign pipe_data[0]  = op_data;

        for (genvar k = 0; k < LATENCY; k++) begin : g_stage
            logic rdy_in;
            logic rdy_out;

            // Each link of the ready chain is its own net so the chain never loops through one vector.
            if (k == LATENCY - 1) begin : g_last
                assign rdy_in = result_ready;
            end else begin : g_mid
                assign rdy_in = g_stage[k+1].rdy_out;
            end

            elastic_reg_stage #(
                .DATA_TYPE (DATA_TYPE)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .data_i  (pipe_data[k]),
                .valid_i (pipe_valid[k]),
                .ready_o (rdy_out),
                .data_o  (pipe_data[k+1]),
                .valid_o (pipe_valid[k+1]),
                .ready_i (rdy_in)
            );
        end

        assign s0_ready     = g_stage[0].rdy_out;
        assign result       = pipe_data[LATENCY];
        assign result_valid = pipe_valid[LATENCY];
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomized checks of logic_unit_pipe at several widths and latencies.
module tb_logic_unit_pipe;
    import logic_unit_pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    // ---------------- directed instances: A (8b, L=2), B (8b, L=3), C (8b, L=0)
    logic       a_rst, a_lv, a_rv, a_ov, a_lr, a_rr, a_or, a_res_v, a_res_rdy;
    logic [7:0] a_l, a_r, a_res;
    logic [1:0] a_o;
    logic       b_rst, b_lv, b_rv, b_ov, b_lr, b_rr, b_or, b_res_v, b_res_rdy;
    logic [7:0] b_l, b_r, b_res;
    logic [1:0] b_o;
    logic       c_rst, c_lv, c_rv, c_ov, c_lr, c_rr, c_or, c_res_v, c_res_rdy;
    logic [7:0] c_l, c_r, c_res;
    logic [1:0] c_o;

    logic_unit_pipe #(.DATA_TYPE(8), .LATENCY(2)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .lhs(a_l), .lhs_valid(a_lv), .lhs_ready(a_lr),
        .rhs(a_r), .rhs_valid(a_rv), .rhs_ready(a_rr),
        .op(a_o), .op_valid(a_ov), .op_ready(a_or),
        .result(a_res), .result_valid(a_res_v), .result_ready(a_res_rdy)
    );

    logic_unit_pipe #(.DATA_TYPE(8), .LATENCY(3)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .lhs(b_l), .lhs_valid(b_lv), .lhs_ready(b_lr),
        .rhs(b_r), .rhs_valid(b_rv), .rhs_ready(b_rr),
        .op(b_o), .op_valid(b_ov), .op_ready(b_or),
        .result(b_res), .result_valid(b_res_v), .result_ready(b_res_rdy)
    );

    logic_unit_pipe #(.DATA_TYPE(8), .LATENCY(0)) u_dut_c (
        .clk(clk), .rst(c_rst),
        .lhs(c_l), .lhs_valid(c_lv), .lhs_ready(c_lr),
        .rhs(c_r), .rhs_valid(c_rv), .rhs_ready(c_rr),
        .op(c_o), .op_valid(c_ov), .op_ready(c_or),
        .result(c_res), .result_valid(c_res_v), .result_ready(c_res_rdy)
    );

    // ---------------- randomized instances: 32b, LATENCY in {0,1,4}
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 4);

        logic        rst, lv, rv, ov, lr, rr, orr, res_v, res_rdy;
        logic [31:0] l, r, res;
        logic [1:0]  o;
        logic        done = 1'b0;

        logic_unit_pipe #(.DATA_TYPE(32), .LATENCY(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .lhs(l), .lhs_valid(lv), .lhs_ready(lr),
            .rhs(r), .rhs_valid(rv), .rhs_ready(rr),
            .op(o), .op_valid(ov), .op_ready(orr),
            .result(res), .result_valid(res_v), .result_ready(res_rdy)
        );

        initial begin
            logic [31:0] q[$];
            logic [31:0] held;
            logic        stalled;
            logic        s0;
            logic        fire;
            rst = 1'b1; lv = 1'b0; rv = 1'b0; ov = 1'b0; res_rdy = 1'b0;
            l = '0; r = '0; o = '0;
            held = '0; stalled = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            for (int c = 0; c < 10000; c++) begin
                @(posedge clk);
                #1;
                if (c < 9980) begin
                    lv = ($urandom_range(0, 3) != 0);
                    rv = ($urandom_range(0, 3) != 0);
                    ov = ($urandom_range(0, 3) != 0);
                    l  = $urandom;
                    r  = $urandom;
                    o  = 2'($urandom_range(0, 3));
                    if ((c / 256) % 4 == 3) res_rdy = ($urandom_range(0, 7) == 0);
                    else                    res_rdy = ($urandom_range(0, 3) != 0);
                end else begin
                    lv = 1'b0; rv = 1'b0; ov = 1'b0; res_rdy = 1'b1;
                end
                @(negedge clk);
                // Input side can take a token unless every stage is occupied and the output is stalled.
                s0 = (q.size() < LAT) || res_rdy;
                check("rnd_lhs_ready", lr,  rv & ov & s0);
                check("rnd_rhs_ready", rr,  lv & ov & s0);
                check("rnd_op_ready",  orr, lv & rv & s0);
                if (stalled) begin
                    check("rnd_hold_valid", res_v, 1'b1);
                    check("rnd_hold_data",  res,   held);
                end
                fire = lv & rv & ov & lr;
                if (fire && LAT == 0) q.push_back(ref_op(l, r, o));
                if (res_v && res_rdy) begin
                    if (q.size() == 0) check("rnd_spurious_out", res_v & res_rdy, 1'b0);
                    else               check("rnd_data", res, q.pop_front());
                end
                if (fire && LAT != 0) q.push_back(ref_op(l, r, o));
                stalled = res_v & ~res_rdy & (LAT > 0);
                held    = res;
            end
            check("rnd_drained", 32'(q.size()), 32'd0);
            done = 1'b1;
        end
    end

    // ---------------- directed sequences on instance A
    task automatic a_ops();
        logic [7:0] exp_res [4];
        exp_res[0] = 8'h30; exp_res[1] = 8'hFC; exp_res[2] = 8'hCC; exp_res[3] = 8'h33;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            a_res_rdy = 1'b1;
            if (k < 4) begin
                a_lv = 1'b1; a_rv = 1'b1; a_ov = 1'b1;
                a_l = 8'hF0; a_r = 8'h3C; a_o = 2'(k);
            end else begin
                a_lv = 1'b0; a_rv = 1'b0; a_ov = 1'b0;
            end
            @(negedge clk);
            if (k < 4) check("a_ops_fire", a_lr & a_rr & a_or, 1'b1);
            if (k >= 2) begin
                check("a_ops_valid", a_res_v, 1'b1);
                check("a_ops_data",  a_res,   exp_res[k-2]);
            end else begin
                check("a_ops_latency", a_res_v, 1'b0);
            end
        end
    endtask

    task automatic a_skew();
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
            a_res_rdy = 1'b1;
            a_l = 8'h5A; a_r = 8'h0F; a_o = OP_XOR;
            a_lv = (c <= 4);
            a_rv = (c >= 2 && c <= 4);
            a_ov = (c == 4);
            @(negedge clk);
            if (c < 4) begin
                check("a_skew_lhs_ready", a_lr, 1'b0);
                check("a_skew_rhs_ready", a_rr, 1'b0);
                check("a_skew_op_ready",  a_or, (c >= 2) ? 1'b1 : 1'b0);
            end else if (c == 4) begin
                check("a_skew_fire", {a_lr, a_rr, a_or}, 3'b111);
            end
            check("a_skew_out_valid", a_res_v, (c == 6) ? 1'b1 : 1'b0);
            if (c == 6) check("a_skew_out_data", a_res, 8'h55);
        end
    endtask

    task automatic a_flush();
        for (int c = 0; c < 11; c++) begin
            @(posedge clk);
            #1;
            a_rst = (c == 2);
            a_res_rdy = (c >= 4);
            a_lv = 1'b0; a_rv = 1'b0; a_ov = 1'b0;
            case (c)
                0: begin a_lv = 1'b1; a_rv = 1'b1; a_ov = 1'b1; a_l = 8'h11; a_r = 8'h22; a_o = OP_OR;  end
                1: begin a_lv = 1'b1; a_rv = 1'b1; a_ov = 1'b1; a_l = 8'hFF; a_r = 8'h0F; a_o = OP_AND; end
                7: begin a_lv = 1'b1; a_rv = 1'b1; a_ov = 1'b1; a_l = 8'hC3; a_r = 8'h3C; a_o = OP_XOR; end
                default: ;
            endcase
            @(negedge clk);
            case (c)
                0, 1, 7: check("a_flush_fire", a_lr, 1'b1);
                2: begin
                    check("a_flush_head_valid", a_res_v, 1'b1);
                    check("a_flush_head_data",  a_res,   8'h33);
                end
                3: begin
                    check("a_flush_rst_valid", a_res_v, 1'b0);
                    check("a_flush_rst_data",  a_res,   8'h00);
                end
                default: ;
            endcase
            if (c >= 3) check("a_flush_out_valid", a_res_v, (c == 9) ? 1'b1 : 1'b0);
            if (c == 9) check("a_flush_new_data", a_res, 8'hFF);
        end
    endtask

    // ---------------- backpressure on instance B
    task automatic b_backpressure();
        logic [7:0] tl [5];
        logic [7:0] tr [5];
        logic [1:0] to [5];
        logic [7:0] te [5];
        int j;
        for (int i = 0; i < 5; i++) begin
            tl[i] = 8'(i * 37 + 5);
            tr[i] = 8'(i * 91 + 11);
            to[i] = 2'(i);
            te[i] = 8'(ref_op(32'(tl[i]), 32'(tr[i]), to[i]));
        end
        j = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            b_res_rdy = (c >= 8);
            b_lv = (j < 5); b_rv = (j < 5); b_ov = (j < 5);
            if (j < 5) begin b_l = tl[j]; b_r = tr[j]; b_o = to[j]; end
            @(negedge clk);
            if (c == 7) begin
                check("b_accepted", 32'(j), 32'd3);
                check("b_full_ready", {b_lr, b_rr, b_or}, 3'b000);
            end
            if (c >= 5 && c < 8) begin
                check("b_stall_valid", b_res_v, 1'b1);
                check("b_stall_data",  b_res,   te[0]);
            end
            if (c >= 8) begin
                check("b_drain_valid", b_res_v, (c < 13) ? 1'b1 : 1'b0);
                if (c < 13) check("b_drain_data", b_res, te[c-8]);
            end
            if (b_lv && b_rv && b_ov && b_lr) j++;
        end
        check("b_all_accepted", 32'(j), 32'd5);
        @(posedge clk);
        #1 b_lv = 1'b0; b_rv = 1'b0; b_ov = 1'b0;
    endtask

    // ---------------- combinational path on instance C
    task automatic c_comb();
        @(posedge clk);
        #1;
        c_lv = 1'b1; c_rv = 1'b1; c_ov = 1'b1; c_res_rdy = 1'b1;
        c_l = 8'hAA; c_r = 8'h55; c_o = OP_XNOR;
        @(negedge clk);
        check("c_xnor_valid", c_res_v, 1'b1);
        check("c_xnor_data",  c_res,   8'h00);
        check("c_ready",      {c_lr, c_rr, c_or}, 3'b111);
        @(posedge clk);
        #1 c_o = OP_OR;
        @(negedge clk);
        check("c_or_data", c_res, 8'hFF);
        @(posedge clk);
        #1 c_res_rdy = 1'b0;
        @(negedge clk);
        check("c_stall_ready", {c_lr, c_rr, c_or}, 3'b000);
        check("c_stall_valid", c_res_v, 1'b1);
        @(posedge clk);
        #1 c_lv = 1'b0;
        @(negedge clk);
        check("c_idle_valid", c_res_v, 1'b0);
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_lv = 1'b0; a_rv = 1'b0; a_ov = 1'b0; a_res_rdy = 1'b0; a_l = '0; a_r = '0; a_o = '0;
        b_lv = 1'b0; b_rv = 1'b0; b_ov = 1'b0; b_res_rdy = 1'b0; b_l = '0; b_r = '0; b_o = '0;
        c_lv = 1'b0; c_rv = 1'b0; c_ov = 1'b0; c_res_rdy = 1'b0; c_l = '0; c_r = '0; c_o = '0;
        repeat (2) @(posedge clk);
        #1 a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        @(negedge clk);
        check("a_rst_valid", a_res_v, 1'b0);
        check("a_rst_data",  a_res,   8'h00);
        check("a_rst_ready", {a_lr, a_rr, a_or}, 3'b000);
        check("b_rst_valid", b_res_v, 1'b0);
        check("b_rst_data",  b_res,   8'h00);

        @(posedge clk);
        #1 a_rv = 1'b1; a_ov = 1'b1;
        @(negedge clk);
        check("a_idle_lhs_ready", a_lr, 1'b1);
        check("a_idle_rhs_ready", a_rr, 1'b0);
        check("a_idle_op_ready",  a_or, 1'b0);

        a_ops();
        a_skew();
        a_flush();
        b_backpressure();
        c_comb();

        for (int i = 0; i < 12000; i++) begin
            if (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) break;
            @(posedge clk);
        end
        check("rnd_finished", {g_rnd[2].done, g_rnd[1].done, g_rnd[0].done}, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
